// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding selects, per-stage enable/bubble control,
// data-memory wait sequencing with a watchdog halt, and saturating event counters.
module hazard_ctrl #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       rs1_id_i,
   input  logic [4:0]       rs2_id_i,
   input  logic [4:0]       rs1_ex_i,
   input  logic [4:0]       rs2_ex_i,
   input  logic [4:0]       rsW_ex_i,
   input  logic [4:0]       rsW_mem_i,
   input  logic [4:0]       rsW_wb_i,
   input  logic             RegWEn_ex_i,
   input  logic             RegWEn_mem_i,
   input  logic             RegWEn_wb_i,
   input  logic [1:0]       WBSel_ex_i,
   input  logic [1:0]       WBSel_mem_i,
   input  logic             br_ex_i,
   input  logic             taken_ex_i,
   input  logic             pred_taken_ex_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   output logic [1:0]       Asel_haz_o,
   output logic [1:0]       Bsel_haz_o,
   output logic             pc_en_o,
   output logic             ifid_en_o,
   output logic             ifid_rst_o,
   output logic             idex_en_o,
   output logic             idex_rst_o,
   output logic             exmem_en_o,
   output logic             exmem_rst_o,
   output logic             memwb_en_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [CNT_W-1:0] wait_cnt_o
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

   state_t            state_q, state_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q, wait_cnt_q;
   logic              freeze, halt, mispredict, load_use, stall_app, flush_app;
   logic [1:0]        fwd_sel [2];
   logic [4:0]        rs_ex [2];

   assign rs_ex[0] = rs1_ex_i;
   assign rs_ex[1] = rs2_ex_i;

   // MEM forwards only ALU results; loads and pc4 in MEM arrive later via WB.
   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
         fwd_sel[gi] = 2'b00;
         if (RegWEn_mem_i && rsW_mem_i != 5'd0 && rsW_mem_i == rs_ex[gi] && WBSel_mem_i == 2'b01)
            fwd_sel[gi] = 2'b01;
         else if (RegWEn_wb_i && rsW_wb_i != 5'd0 && rsW_wb_i == rs_ex[gi])
            fwd_sel[gi] = 2'b10;
      end
   end

   assign mispredict = br_ex_i && (taken_ex_i != pred_taken_ex_i);
   assign load_use   = RegWEn_ex_i && rsW_ex_i != 5'd0 && WBSel_ex_i != 2'b01 &&
                       (rsW_ex_i == rs1_id_i || rsW_ex_i == rs2_id_i);

   always_comb begin
      state_d = state_q;
      wdog_d  = wdog_q;
      freeze  = 1'b0;
      halt    = 1'b0;
      case (state_q)
         RUN: begin
            if (mem_req_i && !mem_ready_i) begin
               freeze  = 1'b1;
               state_d = MEM_WAIT;
               wdog_d  = WD_W'(1);
            end
         end
         MEM_WAIT: begin
            if (mem_ready_i) begin
               state_d = RUN;
            end else begin
               freeze = 1'b1;
               if (wdog_q == WD_W'(TIMEOUT - 1))
                  state_d = ERR;
               else
                  wdog_d = wdog_q + WD_W'(1);
            end
         end
         default: halt = 1'b1;
      endcase
   end

   always_comb begin
      stall_app   = 1'b0;
      flush_app   = 1'b0;
      pc_en_o     = 1'b1;
      ifid_en_o   = 1'b1;
      ifid_rst_o  = 1'b0;
      idex_en_o   = 1'b1;
      idex_rst_o  = 1'b0;
      exmem_en_o  = 1'b1;
      exmem_rst_o = 1'b0;
      memwb_en_o  = 1'b1;
      Asel_haz_o  = rst_i ? 2'b00 : fwd_sel[0];
      Bsel_haz_o  = rst_i ? 2'b00 : fwd_sel[1];
      if (rst_i || halt || freeze) begin
         pc_en_o    = 1'b0;
         ifid_en_o  = 1'b0;
         idex_en_o  = 1'b0;
         exmem_en_o = 1'b0;
         memwb_en_o = 1'b0;
      end else if (mispredict) begin
         flush_app  = 1'b1;
         ifid_rst_o = 1'b1;
         idex_rst_o = 1'b1;
      end else if (load_use) begin
         stall_app  = 1'b1;
         pc_en_o    = 1'b0;
         ifid_en_o  = 1'b0;
         idex_rst_o = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         wdog_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wdog_q  <= wdog_d;
         if (stall_app && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_app && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         if (freeze && !(&wait_cnt_q))     wait_cnt_q  <= wait_cnt_q + CNT_W'(1);
      end
   end

   assign err_o       = (state_q == ERR);
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
   assign wait_cnt_o  = wait_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for combinational control,
// hand-written sequences for stall, freeze, watchdog, saturation and reset.
module tb_hazard_ctrl;

   localparam logic [7:0] NORM  = 8'b1101_0101;
   localparam logic [7:0] STALL = 8'b0001_1101;
   localparam logic [7:0] FLUSH = 8'b1111_1101;
   localparam logic [7:0] HALT  = 8'b0000_0000;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rsw_ex, rsw_mem, rsw_wb;
   logic wen_ex, wen_mem, wen_wb;
   logic [1:0] wbs_ex, wbs_mem;
   logic br, taken, pred, req, rdy;

   logic [1:0] asel, bsel, s_asel, s_bsel;
   logic pc_en, ifid_en, ifid_rst, idex_en, idex_rst, exmem_en, exmem_rst, memwb_en, err;
   logic s_pc_en, s_ifid_en, s_ifid_rst, s_idex_en, s_idex_rst, s_exmem_en, s_exmem_rst, s_memwb_en, s_err;
   logic [15:0] stall_cnt, flush_cnt, wait_cnt;
   logic [1:0]  s_stall_cnt, s_flush_cnt, s_wait_cnt;
   logic [7:0]  ctl, s_ctl;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign ctl   = {pc_en, ifid_en, ifid_rst, idex_en, idex_rst, exmem_en, exmem_rst, memwb_en};
   assign s_ctl = {s_pc_en, s_ifid_en, s_ifid_rst, s_idex_en, s_idex_rst, s_exmem_en, s_exmem_rst, s_memwb_en};

   hazard_ctrl #(.CNT_W(16), .TIMEOUT(4)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .rs1_id_i(rs1_id), .rs2_id_i(rs2_id), .rs1_ex_i(rs1_ex), .rs2_ex_i(rs2_ex),
      .rsW_ex_i(rsw_ex), .rsW_mem_i(rsw_mem), .rsW_wb_i(rsw_wb),
      .RegWEn_ex_i(wen_ex), .RegWEn_mem_i(wen_mem), .RegWEn_wb_i(wen_wb),
      .WBSel_ex_i(wbs_ex), .WBSel_mem_i(wbs_mem),
      .br_ex_i(br), .taken_ex_i(taken), .pred_taken_ex_i(pred),
      .mem_req_i(req), .mem_ready_i(rdy),
      .Asel_haz_o(asel), .Bsel_haz_o(bsel),
      .pc_en_o(pc_en), .ifid_en_o(ifid_en), .ifid_rst_o(ifid_rst),
      .idex_en_o(idex_en), .idex_rst_o(idex_rst),
      .exmem_en_o(exmem_en), .exmem_rst_o(exmem_rst), .memwb_en_o(memwb_en),
      .err_o(err), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .wait_cnt_o(wait_cnt)
   );

   hazard_ctrl #(.CNT_W(2), .TIMEOUT(4)) u_sat (
      .clk_i(clk), .rst_i(rst),
      .rs1_id_i(rs1_id), .rs2_id_i(rs2_id), .rs1_ex_i(rs1_ex), .rs2_ex_i(rs2_ex),
      .rsW_ex_i(rsw_ex), .rsW_mem_i(rsw_mem), .rsW_wb_i(rsw_wb),
      .RegWEn_ex_i(wen_ex), .RegWEn_mem_i(wen_mem), .RegWEn_wb_i(wen_wb),
      .WBSel_ex_i(wbs_ex), .WBSel_mem_i(wbs_mem),
      .br_ex_i(br), .taken_ex_i(taken), .pred_taken_ex_i(pred),
      .mem_req_i(req), .mem_ready_i(rdy),
      .Asel_haz_o(s_asel), .Bsel_haz_o(s_bsel),
      .pc_en_o(s_pc_en), .ifid_en_o(s_ifid_en), .ifid_rst_o(s_ifid_rst),
      .idex_en_o(s_idex_en), .idex_rst_o(s_idex_rst),
      .exmem_en_o(s_exmem_en), .exmem_rst_o(s_exmem_rst), .memwb_en_o(s_memwb_en),
      .err_o(s_err), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt), .wait_cnt_o(s_wait_cnt)
   );

   typedef struct {
      logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rsw_ex, rsw_mem, rsw_wb;
      logic       wen_ex, wen_mem, wen_wb;
      logic [1:0] wbs_ex, wbs_mem;
      logic       br, taken, pred, req, rdy;
      logic [1:0] ea, eb;
      logic [7:0] ectl;
   } vec_t;

   vec_t vecs [20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      rs1_id = 5'd1; rs2_id = 5'd2; rs1_ex = 5'd3; rs2_ex = 5'd4;
      rsw_ex = 5'd0; rsw_mem = 5'd0; rsw_wb = 5'd0;
      wen_ex = 1'b0; wen_mem = 1'b0; wen_wb = 1'b0;
      wbs_ex = 2'b01; wbs_mem = 2'b01;
      br = 1'b0; taken = 1'b0; pred = 1'b0; req = 1'b0; rdy = 1'b0;
   endtask

   task automatic load_use();
      rs1_id = 5'd6; rs2_id = 5'd1; rsw_ex = 5'd6; wen_ex = 1'b1; wbs_ex = 2'b00;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      rs1_ex = 5'd5; rsw_mem = 5'd5; wen_mem = 1'b1;
      #1;
      chk("rst_ctl", {24'd0, ctl}, {24'd0, HALT});
      chk("rst_fwd", {28'd0, asel, bsel}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{5'd1,5'd2,5'd5,5'd5, 5'd0,5'd5,5'd0, 1'b0,1'b1,1'b0, 2'b01,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b01, NORM};
      vecs[1]  = '{5'd1,5'd2,5'd5,5'd5, 5'd0,5'd0,5'd5, 1'b0,1'b0,1'b1, 2'b01,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b10, NORM};
      vecs[2]  = '{5'd1,5'd2,5'd5,5'd5, 5'd0,5'd5,5'd5, 1'b0,1'b1,1'b1, 2'b01,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b01, NORM};
      vecs[3]  = '{5'd1,5'd2,5'd0,5'd0, 5'd0,5'd0,5'd0, 1'b0,1'b1,1'b1, 2'b01,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, NORM};
      vecs[4]  = '{5'd1,5'd2,5'd5,5'd5, 5'd0,5'd5,5'd5, 1'b0,1'b1,1'b1, 2'b01,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b10, NORM};
      vecs[5]  = '{5'd1,5'd2,5'd5,5'd5, 5'd0,5'd5,5'd5, 1'b0,1'b0,1'b1, 2'b01,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b10, NORM};
      vecs[6]  = '{5'd1,5'd2,5'd5,5'd6, 5'd0,5'd5,5'd6, 1'b0,1'b1,1'b1, 2'b01,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b10, NORM};
      vecs[7]  = '{5'd1,5'd2,5'd5,5'd5, 5'd0,5'd5,5'd0, 1'b0,1'b1,1'b0, 2'b01,2'b10, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, NORM};
      vecs[8]  = '{5'd6,5'd1,5'd0,5'd0, 5'd6,5'd0,5'd0, 1'b1,1'b0,1'b0, 2'b00,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, STALL};
      vecs[9]  = '{5'd1,5'd6,5'd0,5'd0, 5'd6,5'd0,5'd0, 1'b1,1'b0,1'b0, 2'b10,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, STALL};
      vecs[10] = '{5'd0,5'd0,5'd0,5'd0, 5'd0,5'd0,5'd0, 1'b1,1'b0,1'b0, 2'b00,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, NORM};
      vecs[11] = '{5'd6,5'd1,5'd0,5'd0, 5'd6,5'd0,5'd0, 1'b1,1'b0,1'b0, 2'b01,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, NORM};
      vecs[12] = '{5'd6,5'd1,5'd0,5'd0, 5'd6,5'd0,5'd0, 1'b0,1'b0,1'b0, 2'b00,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, NORM};
      vecs[13] = '{5'd1,5'd2,5'd0,5'd0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0, 2'b01,2'b01, 1'b1,1'b0,1'b1,1'b0,1'b0, 2'b00,2'b00, FLUSH};
      vecs[14] = '{5'd1,5'd2,5'd0,5'd0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0, 2'b01,2'b01, 1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00, FLUSH};
      vecs[15] = '{5'd1,5'd2,5'd0,5'd0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0, 2'b01,2'b01, 1'b1,1'b1,1'b1,1'b0,1'b0, 2'b00,2'b00, NORM};
      vecs[16] = '{5'd1,5'd2,5'd0,5'd0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0, 2'b01,2'b01, 1'b0,1'b0,1'b1,1'b0,1'b0, 2'b00,2'b00, NORM};
      vecs[17] = '{5'd6,5'd1,5'd0,5'd0, 5'd6,5'd0,5'd0, 1'b1,1'b0,1'b0, 2'b00,2'b01, 1'b1,1'b0,1'b1,1'b0,1'b0, 2'b00,2'b00, FLUSH};
      vecs[18] = '{5'd1,5'd2,5'd0,5'd0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0, 2'b01,2'b01, 1'b0,1'b0,1'b0,1'b1,1'b1, 2'b00,2'b00, NORM};
      vecs[19] = '{5'd1,5'd2,5'd0,5'd0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0, 2'b01,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, NORM};

      rst = 1'b1;
      idle();
      do_reset();
      #1;
      chk("reset_err", {31'd0, err}, 32'd0);
      chk("reset_cnts", {stall_cnt, flush_cnt}, 32'd0);
      chk("reset_wait", {16'd0, wait_cnt}, 32'd0);

      // combinational control, all in RUN
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         rs1_id = vecs[i].rs1_id; rs2_id = vecs[i].rs2_id;
         rs1_ex = vecs[i].rs1_ex; rs2_ex = vecs[i].rs2_ex;
         rsw_ex = vecs[i].rsw_ex; rsw_mem = vecs[i].rsw_mem; rsw_wb = vecs[i].rsw_wb;
         wen_ex = vecs[i].wen_ex; wen_mem = vecs[i].wen_mem; wen_wb = vecs[i].wen_wb;
         wbs_ex = vecs[i].wbs_ex; wbs_mem = vecs[i].wbs_mem;
         br = vecs[i].br; taken = vecs[i].taken; pred = vecs[i].pred;
         req = vecs[i].req; rdy = vecs[i].rdy;
         #1;
         chk($sformatf("vec%0d_asel", i), {30'd0, asel}, {30'd0, vecs[i].ea});
         chk($sformatf("vec%0d_bsel", i), {30'd0, bsel}, {30'd0, vecs[i].eb});
         chk($sformatf("vec%0d_ctl", i), {24'd0, ctl}, {24'd0, vecs[i].ectl});
         chk($sformatf("vec%0d_sat", i), {20'd0, s_asel, s_bsel, s_ctl}, {20'd0, vecs[i].ea, vecs[i].eb, vecs[i].ectl});
         $display("[TB] vec %0d asel=%b bsel=%b ctl=%b", i, asel, bsel, ctl);
      end

      // load-use: one stall cycle, bubble in EX next, then WB forwarding
      do_reset();
      @(negedge clk);
      load_use();
      #1;
      chk("lu_stall_ctl", {24'd0, ctl}, {24'd0, STALL});
      @(negedge clk);
      idle();
      #1;
      chk("lu_release_ctl", {24'd0, ctl}, {24'd0, NORM});
      chk("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
      @(negedge clk);
      rs1_ex = 5'd6; rsw_wb = 5'd6; wen_wb = 1'b1;
      #1;
      chk("lu_fwd_wb", {30'd0, asel}, 32'd2);
      $display("[TB] load-use stall_cnt=%0d asel=%b", stall_cnt, asel);

      // mispredict coinciding with load-use: flush only
      @(negedge clk);
      idle();
      load_use();
      br = 1'b1; pred = 1'b1; taken = 1'b0;
      #1;
      chk("mp_lu_ctl", {24'd0, ctl}, {24'd0, FLUSH});
      @(negedge clk);
      idle();
      #1;
      chk("mp_lu_flush_cnt", {16'd0, flush_cnt}, 32'd1);
      chk("mp_lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
      $display("[TB] mispredict+stall flush=%0d stall=%0d", flush_cnt, stall_cnt);

      // memory wait: 3 frozen cycles with a pending mispredict, then release
      do_reset();
      @(negedge clk);
      req = 1'b1; rdy = 1'b0;
      br = 1'b1; pred = 1'b1; taken = 1'b0;
      rs1_ex = 5'd5; rsw_mem = 5'd5; wen_mem = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("mw_freeze%0d_ctl", i), {24'd0, ctl}, {24'd0, HALT});
         chk($sformatf("mw_freeze%0d_fwd", i), {30'd0, asel}, 32'd1);
         @(negedge clk);
      end
      rdy = 1'b1;
      #1;
      chk("mw_release_ctl", {24'd0, ctl}, {24'd0, FLUSH});
      @(negedge clk);
      idle();
      #1;
      chk("mw_wait_cnt", {16'd0, wait_cnt}, 32'd3);
      chk("mw_flush_cnt", {16'd0, flush_cnt}, 32'd1);
      chk("mw_run_ctl", {24'd0, ctl}, {24'd0, NORM});
      chk("mw_err", {31'd0, err}, 32'd0);
      $display("[TB] mem wait wait_cnt=%0d flush_cnt=%0d", wait_cnt, flush_cnt);

      // watchdog: 4 frozen cycles then sticky ERR
      do_reset();
      @(negedge clk);
      req = 1'b1; rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("wd_freeze%0d_ctl", i), {24'd0, ctl}, {24'd0, HALT});
         chk($sformatf("wd_freeze%0d_err", i), {31'd0, err}, 32'd0);
         @(negedge clk);
      end
      rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("wd_err%0d", i), {30'd0, err, s_err}, 32'd3);
         chk($sformatf("wd_err%0d_ctl", i), {24'd0, ctl}, {24'd0, HALT});
         @(negedge clk);
      end
      #1;
      chk("wd_wait_cnt", {16'd0, wait_cnt}, 32'd4);
      do_reset();
      #1;
      chk("wd_rst_err", {31'd0, err}, 32'd0);
      chk("wd_rst_cnts", {stall_cnt, flush_cnt}, 32'd0);
      chk("wd_rst_wait", {16'd0, wait_cnt}, 32'd0);
      chk("wd_rst_ctl", {24'd0, ctl}, {24'd0, NORM});
      $display("[TB] watchdog cleared err=%0d ctl=%b", err, ctl);

      // saturation: 5 stalls on a 2-bit counter
      @(negedge clk);
      load_use();
      for (int i = 0; i < 5; i++) @(negedge clk);
      idle();
      #1;
      chk("sat_stall_2b", {30'd0, s_stall_cnt}, 32'd3);
      chk("sat_stall_16b", {16'd0, stall_cnt}, 32'd5);
      $display("[TB] saturation s_stall=%0d stall=%0d", s_stall_cnt, stall_cnt);

      // reset while in MEM_WAIT
      @(negedge clk);
      req = 1'b1; rdy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      do_reset();
      req = 1'b0; rdy = 1'b0;
      #1;
      chk("mwrst_ctl", {24'd0, ctl}, {24'd0, NORM});
      chk("mwrst_wait", {16'd0, wait_cnt}, 32'd0);
      chk("mwrst_sat_cnts", {26'd0, s_stall_cnt, s_flush_cnt, s_wait_cnt}, 32'd0);
      $display("[TB] reset in MEM_WAIT ctl=%b wait=%0d", ctl, wait_cnt);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
